mem_port_arbiter: RTL and testbench

- Shares one single-port memory (RAMHelper-style, 64-bit word, byte-lane wmask) between the instruction-fetch requester (IF) and the load/store requester (LS).
- One transaction is outstanding at a time. LS has priority, with a starvation guard for IF.
- Sits between the core's fetch/LSU and the memory wrapper. It replaces the separate instruction and data ports with a sequenced, registered request path.

---
 rtl/mem_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch (IF) and
// load/store (LS): one transaction in flight, LS priority, IF starvation guard.
module mem_port_arbiter #(
  parameter int AW           = 64,
  parameter int DW           = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ready,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,

  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  input  logic [DW-1:0] ls_wmask,
  output logic          ls_ready,
  output logic          ls_rvalid,
  output logic [DW-1:0] ls_rdata,

  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [DW-1:0] mem_wmask,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state;
  logic       owner_ls;
  logic [3:0] streak;
  logic       pick_ls;
  logic       pick_if;

  // Grant is combinational so the winner sees ready in the same IDLE cycle.
  // Reset gates it so every output reads 0 while rst is held.
  always_comb begin
    // NOTE: defaults first keep every path assigned, so no latch is inferred.
    pick_ls = 1'b0;
    pick_if = 1'b0;
    if (state == IDLE && !rst) begin
      if (ls_req && if_req) begin
        if (streak == LIMIT) pick_if = 1'b1;
        else                 pick_ls = 1'b1;
      end else if (ls_req) begin
        pick_ls = 1'b1;
      end else if (if_req) begin
        pick_if = 1'b1;
      end
    end
  end

  assign if_ready = pick_if;
  assign ls_ready = pick_ls;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner_ls  <= 1'b0;
      streak    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      ls_rvalid <= 1'b0;
      ls_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_ls) begin
            mem_req   <= 1'b1;
            mem_we    <= ls_we;
            mem_addr  <= ls_addr;
            mem_wdata <= ls_wdata;
            mem_wmask <= ls_wmask;
            owner_ls  <= 1'b1;
            state     <= ISSUE;
            // Streak only grows while IF is actually being passed over.
            if (if_req) streak <= (streak >= LIMIT) ? LIMIT : streak + 4'd1;
            else        streak <= '0;
          end else if (pick_if) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            mem_wmask <= '0;
            owner_ls  <= 1'b0;
            state     <= ISSUE;
            streak    <= '0;
          end
        end

        ISSUE: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= WAIT;
          end
        end

        WAIT: begin
          if (mem_rvalid) begin
            // Writes are acknowledged without disturbing either rdata register.
            if (!mem_we) begin
              if (owner_ls) ls_rdata <= mem_rdata;
              else          if_rdata <= mem_rdata;
            end
            if (owner_ls) ls_rvalid <= 1'b1;
            else          if_rvalid <= 1'b1;
            state <= RESP;
          end
        end

        RESP: begin
          if_rvalid <= 1'b0;
          ls_rvalid <= 1'b0;
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: single transactions, gnt stall,
// LS/IF starvation ordering, streak clearing, reset abort, spurious rvalid.
module tb_mem_port_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;

  logic          clk;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ready;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          ls_req;
  logic          ls_we;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata;
  logic [DW-1:0] ls_wmask;
  logic          ls_ready;
  logic          ls_rvalid;
  logic [DW-1:0] ls_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_wmask;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_wmask(ls_wmask), .ls_ready(ls_ready), .ls_rvalid(ls_rvalid),
    .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 2 time units after each rising edge, far from the next one.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Runs one zero-wait transaction from IDLE; returns 1 = LS won, 2 = IF won.
  task automatic grant_cycle(output int who);
    #1;
    who = ls_ready ? 1 : (if_ready ? 2 : 0);
    if (ls_ready && if_ready) who = 3;
    mem_gnt = 1'b1;
    tick();
    tick();
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    tick();
  endtask

  int who;
  int exp_order [10] = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};

  initial begin
    rst = 1'b1; if_req = 0; if_addr = '0; ls_req = 0; ls_we = 0;
    ls_addr = '0; ls_wdata = '0; ls_wmask = '0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    tick(); tick();

    // Reset state, including ready suppression while rst is held.
    if_req = 1'b1; ls_req = 1'b1;
    #1;
    check("rst_if_ready", if_ready, 0);
    check("rst_ls_ready", ls_ready, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_ls_rvalid", ls_rvalid, 0);
    if_req = 1'b0; ls_req = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // IF-only read with gnt tied high.
    mem_gnt = 1'b1; if_req = 1'b1; if_addr = 64'h8000_0008;
    #1;
    check("if_rd_ready_c0", if_ready, 1);
    check("if_rd_lsready_c0", ls_ready, 0);
    tick();
    if_req = 1'b0;
    #1;
    check("if_rd_memreq_c1", mem_req, 1);
    check("if_rd_addr_c1", mem_addr, 64'h8000_0008);
    check("if_rd_we_c1", mem_we, 0);
    check("if_rd_ready_c1", if_ready, 0);
    tick();
    check("if_rd_memreq_c2", mem_req, 0);
    mem_rvalid = 1'b1; mem_rdata = 64'h1122_3344_5566_7788;
    tick();
    mem_rvalid = 1'b0;
    check("if_rd_rvalid_c3", if_rvalid, 1);
    check("if_rd_rdata_c3", if_rdata, 64'h1122_3344_5566_7788);
    check("if_rd_ls_rvalid_c3", ls_rvalid, 0);
    tick();
    check("if_rd_rvalid_c4", if_rvalid, 0);

    // LS write with gnt held off until the third ISSUE cycle.
    mem_gnt = 1'b0;
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 64'h8000_0010;
    ls_wdata = 64'hAB00; ls_wmask = 64'hFF00;
    #1;
    check("ls_wr_ready", ls_ready, 1);
    tick();
    ls_req = 1'b0; ls_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("ls_wr_memreq_%0d", i), mem_req, 1);
      check($sformatf("ls_wr_wmask_%0d", i), mem_wmask, 64'hFF00);
      if (i == 2) mem_gnt = 1'b1;
      tick();
    end
    mem_gnt = 1'b0;
    check("ls_wr_memreq_wait", mem_req, 0);
    check("ls_wr_we", mem_we, 1);
    check("ls_wr_wdata", mem_wdata, 64'hAB00);
    mem_rvalid = 1'b1; mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    mem_rvalid = 1'b0;
    check("ls_wr_rvalid", ls_rvalid, 1);
    check("ls_wr_rdata_kept", ls_rdata, 0);
    check("ls_wr_if_rdata_kept", if_rdata, 64'h1122_3344_5566_7788);
    tick();
    check("ls_wr_rvalid_once", ls_rvalid, 0);

    // Both requesting permanently: LS x4 then IF, twice.
    mem_rdata = 64'h0000_0000_CAFE_0001;
    if_req = 1'b1; ls_req = 1'b1; if_addr = 64'h100; ls_addr = 64'h200;
    for (int i = 0; i < 10; i++) begin
      grant_cycle(who);
      check($sformatf("starve_grant_%0d", i), who, exp_order[i]);
    end
    check("starve_ls_rdata", ls_rdata, 64'h0000_0000_CAFE_0001);

    // Build a streak of 2, then LS grants without IF pending must clear it.
    for (int i = 0; i < 2; i++) begin
      grant_cycle(who);
      check($sformatf("streak_pre_%0d", i), who, 1);
    end
    if_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      grant_cycle(who);
      check($sformatf("streak_lsonly_%0d", i), who, 1);
    end
    if_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      grant_cycle(who);
      check($sformatf("streak_after_%0d", i), who, (i == 4) ? 2 : 1);
    end
    if_req = 1'b0; ls_req = 1'b0;

    // Reset while in WAIT; the late response must be ignored.
    mem_gnt = 1'b1; ls_req = 1'b1; ls_addr = 64'h300;
    tick();
    ls_req = 1'b0;
    tick();
    mem_gnt = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    mem_rvalid = 1'b1; mem_rdata = '1;
    tick();
    mem_rvalid = 1'b0;
    check("abort_ls_rvalid", ls_rvalid, 0);
    check("abort_if_rvalid", if_rvalid, 0);
    check("abort_ls_rdata", ls_rdata, 0);
    check("abort_if_rdata", if_rdata, 0);
    check("abort_mem_req", mem_req, 0);
    check("abort_mem_addr", mem_addr, 0);
    tick();
    check("abort_ls_rvalid_late", ls_rvalid, 0);

    // Spurious rvalid while ISSUE is stalled on gnt.
    if_req = 1'b1; if_addr = 64'h8000_0040;
    tick();
    if_req = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 64'hAAAA_AAAA_AAAA_AAAA;
    tick();
    mem_rvalid = 1'b0;
    check("spur_still_issue", mem_req, 1);
    check("spur_no_rvalid", if_rvalid, 0);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check("spur_wait_no_rvalid", if_rvalid, 0);
    mem_rvalid = 1'b1; mem_rdata = 64'h5555_5555_5555_5555;
    tick();
    mem_rvalid = 1'b0;
    check("spur_rvalid", if_rvalid, 1);
    check("spur_rdata", if_rdata, 64'h5555_5555_5555_5555);
    tick();
    check("spur_rvalid_once", if_rvalid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
